// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pipe_pkg
//  Description : Shared types and constants for the MIPS-style pipeline
//                slice. It provides the opaque control width, the hard-wired
//                zero register number and the forward-source record used by
//                the operand bypass logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    localparam int PIPE_DATA_WIDTH = 32;
    localparam int PIPE_ADDR_WIDTH = 5;
    localparam int CTRL_WIDTH      = 12;

    // Register 0 always reads as zero and is never a real producer target.
    localparam logic [PIPE_ADDR_WIDTH-1:0] REG_ZERO = '0;

    // One candidate producer of a source operand.
    //   wr   : producer writes a register (already qualified by its valid)
    //   dst  : register it writes
    //   data : value it will write
    //   ok   : data is final (0 while a load result is still outstanding)
    typedef struct packed {
        logic                       wr;
        logic [PIPE_ADDR_WIDTH-1:0] dst;
        logic [PIPE_DATA_WIDTH-1:0] data;
        logic                       ok;
    } fwd_src_t;

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/operand_bypass_mux.sv
`default_nettype none
// ============================================================================
//  Module      : operand_bypass_mux
//  Description : Resolves one source operand. Producers are checked youngest
//                first (ID/EX, EX/MEM, MEM/WB), falling back to the register
//                file word. A matching producer whose data is not final
//                raises a hazard, but only when the operand is actually used.
//  Ports       : i_src      - source register number
//                i_use      - instruction reads this source
//                i_idex     - producer in ID/EX
//                i_exmem    - producer in EX/MEM
//                i_memwb    - producer in MEM/WB (always final)
//                i_rf_data  - register file read word
//                o_data     - resolved operand value
//                o_hazard   - operand cannot be resolved this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass_mux
    import mips_pipe_pkg::*;
(
    input  logic [PIPE_ADDR_WIDTH-1:0] i_src,
    input  logic                       i_use,
    input  fwd_src_t                   i_idex,
    input  fwd_src_t                   i_exmem,
    input  fwd_src_t                   i_memwb,
    input  logic [PIPE_DATA_WIDTH-1:0] i_rf_data,
    output logic [PIPE_DATA_WIDTH-1:0] o_data,
    output logic                       o_hazard
);

    logic w_pending;

    always_comb begin
        o_data    = i_rf_data;
        w_pending = 1'b0;
        if (i_src == REG_ZERO) begin
            o_data = '0;
        end else if (i_idex.wr && (i_idex.dst == i_src)) begin
            o_data    = i_idex.data;
            w_pending = ~i_idex.ok;
        end else if (i_exmem.wr && (i_exmem.dst == i_src)) begin
            o_data    = i_exmem.data;
            w_pending = ~i_exmem.ok;
        end else if (i_memwb.wr && (i_memwb.dst == i_src)) begin
            // The RF write lands on the same edge we sample, so the RF
            // word is still stale here.
            o_data = i_memwb.data;
        end
    end

    assign o_hazard = i_use & w_pending;

endmodule : operand_bypass_mux
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_operand_stage
//  Description : Decode-side operand stage. Drives the register file read
//                addresses, resolves RAW hazards by bypass from ID/EX, EX/MEM
//                and MEM/WB or by stalling, and registers operands plus
//                control into the ID/EX pipeline register with a valid/ready
//                handshake toward EX. Counts hazard-stall cycles (saturating).
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                id_*                     - instruction presented by ID
//                id_stall                 - hold IF/ID this cycle
//                rf_rr / rf_q             - register file read address / data
//                ex_data, ex_data_ok      - result of instruction in ID/EX
//                exm_*                    - EX/MEM producer
//                wb_wr, wb_rw, wb_d       - MEM/WB producer (RF write port)
//                flush                    - kill ID/EX contents
//                ex_ready / ex_valid      - handshake toward EX
//                ex_a, ex_b, ex_imm, ex_dst, ex_reg_write, ex_ctrl
//                                         - ID/EX pipeline register
//                stall_cnt                - saturating hazard-stall counter
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
    parameter int ADDR_WIDTH = PIPE_ADDR_WIDTH,
    parameter int CTRL_WIDTH = mips_pipe_pkg::CTRL_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [ADDR_WIDTH-1:0]   id_rs,
    input  logic [ADDR_WIDTH-1:0]   id_rt,
    input  logic                    id_use_rs,
    input  logic                    id_use_rt,
    input  logic [ADDR_WIDTH-1:0]   id_dst,
    input  logic                    id_reg_write,
    input  logic [CTRL_WIDTH-1:0]   id_ctrl,
    input  logic [DATA_WIDTH-1:0]   id_imm,
    output logic                    id_stall,
    output logic [2*ADDR_WIDTH-1:0] rf_rr,
    input  logic [2*DATA_WIDTH-1:0] rf_q,
    input  logic [DATA_WIDTH-1:0]   ex_data,
    input  logic                    ex_data_ok,
    input  logic                    exm_reg_write,
    input  logic [ADDR_WIDTH-1:0]   exm_dst,
    input  logic [DATA_WIDTH-1:0]   exm_data,
    input  logic                    exm_data_ok,
    input  logic                    wb_wr,
    input  logic [ADDR_WIDTH-1:0]   wb_rw,
    input  logic [DATA_WIDTH-1:0]   wb_d,
    input  logic                    flush,
    input  logic                    ex_ready,
    output logic                    ex_valid,
    output logic [DATA_WIDTH-1:0]   ex_a,
    output logic [DATA_WIDTH-1:0]   ex_b,
    output logic [DATA_WIDTH-1:0]   ex_imm,
    output logic [ADDR_WIDTH-1:0]   ex_dst,
    output logic                    ex_reg_write,
    output logic [CTRL_WIDTH-1:0]   ex_ctrl,
    output logic [CNT_WIDTH-1:0]    stall_cnt
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                  r_ex_valid;
    logic [DATA_WIDTH-1:0] r_ex_a;
    logic [DATA_WIDTH-1:0] r_ex_b;
    logic [DATA_WIDTH-1:0] r_ex_imm;
    logic [ADDR_WIDTH-1:0] r_ex_dst;
    logic                  r_ex_reg_write;
    logic [CTRL_WIDTH-1:0] r_ex_ctrl;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    fwd_src_t              w_idex_src;
    fwd_src_t              w_exmem_src;
    fwd_src_t              w_memwb_src;
    logic [DATA_WIDTH-1:0] w_rs_val;
    logic [DATA_WIDTH-1:0] w_rt_val;
    logic                  w_haz_rs;
    logic                  w_haz_rt;
    logic                  w_hazard;
    logic                  w_hold;
    logic                  w_id_fire;

    assign rf_rr = {id_rt, id_rs};

    // A bubble in ID/EX must never forward, hence the ex_valid qualifier.
    assign w_idex_src  = '{wr: r_ex_valid & r_ex_reg_write, dst: r_ex_dst,
                           data: ex_data, ok: ex_data_ok};
    assign w_exmem_src = '{wr: exm_reg_write, dst: exm_dst,
                           data: exm_data, ok: exm_data_ok};
    assign w_memwb_src = '{wr: wb_wr, dst: wb_rw, data: wb_d, ok: 1'b1};

    operand_bypass_mux u_rs_mux (
        .i_src     (id_rs),
        .i_use     (id_use_rs),
        .i_idex    (w_idex_src),
        .i_exmem   (w_exmem_src),
        .i_memwb   (w_memwb_src),
        .i_rf_data (rf_q[DATA_WIDTH-1:0]),
        .o_data    (w_rs_val),
        .o_hazard  (w_haz_rs)
    );

    operand_bypass_mux u_rt_mux (
        .i_src     (id_rt),
        .i_use     (id_use_rt),
        .i_idex    (w_idex_src),
        .i_exmem   (w_exmem_src),
        .i_memwb   (w_memwb_src),
        .i_rf_data (rf_q[2*DATA_WIDTH-1:DATA_WIDTH]),
        .o_data    (w_rt_val),
        .o_hazard  (w_haz_rt)
    );

    assign w_hazard  = id_valid & (w_haz_rs | w_haz_rt);
    assign w_hold    = r_ex_valid & ~ex_ready;
    assign w_id_fire = id_valid & ~w_hazard & ~w_hold & ~flush;
    assign id_stall  = id_valid & ~flush & (w_hazard | w_hold);

    // ID/EX register: flush beats hold, hold beats capture. Only the valid
    // and write-enable bits are cleared on a bubble; payload is don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_a         <= '0;
            r_ex_b         <= '0;
            r_ex_imm       <= '0;
            r_ex_dst       <= '0;
            r_ex_reg_write <= 1'b0;
            r_ex_ctrl      <= '0;
        end else if (flush) begin
            r_ex_valid     <= 1'b0;
            r_ex_reg_write <= 1'b0;
        end else if (w_hold) begin
            r_ex_valid     <= r_ex_valid;
        end else if (w_id_fire) begin
            r_ex_valid     <= 1'b1;
            r_ex_a         <= w_rs_val;
            r_ex_b         <= w_rt_val;
            r_ex_imm       <= id_imm;
            r_ex_dst       <= id_dst;
            r_ex_reg_write <= id_reg_write;
            r_ex_ctrl      <= id_ctrl;
        end else begin
            r_ex_valid     <= 1'b0;
            r_ex_reg_write <= 1'b0;
        end
    end

    // Only stalls caused by an operand hazard are counted; back-pressure
    // from EX and flushed cycles are not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && !w_hold && !flush && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_a         = r_ex_a;
    assign ex_b         = r_ex_b;
    assign ex_imm       = r_ex_imm;
    assign ex_dst       = r_ex_dst;
    assign ex_reg_write = r_ex_reg_write;
    assign ex_ctrl      = r_ex_ctrl;
    assign stall_cnt    = r_stall_cnt;

endmodule : id_ex_operand_stage
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_operand_stage
//  Description : Self-checking bench for id_ex_operand_stage. The bench acts
//                as the register file and keeps a cycle reference model of
//                the ID/EX register and stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 12;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_rs, id_use_rt, id_reg_write;
    logic [AW-1:0] id_rs, id_rt, id_dst;
    logic [CW-1:0] id_ctrl;
    logic [DW-1:0] id_imm;
    logic          id_stall;
    logic [2*AW-1:0] rf_rr;
    logic [2*DW-1:0] rf_q;
    logic [DW-1:0] ex_data, exm_data, wb_d;
    logic          ex_data_ok, exm_reg_write, exm_data_ok, wb_wr;
    logic [AW-1:0] exm_dst, wb_rw;
    logic          flush, ex_ready;
    logic          ex_valid, ex_reg_write;
    logic [DW-1:0] ex_a, ex_b, ex_imm;
    logic [AW-1:0] ex_dst;
    logic [CW-1:0] ex_ctrl;
    logic [NW-1:0] stall_cnt;

    logic [DW-1:0] rf [32];
    assign rf_q = {rf[id_rt], rf[id_rs]};

    always #5 clk = ~clk;

    id_ex_operand_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_reg_write(id_reg_write), .id_ctrl(id_ctrl), .id_imm(id_imm),
        .id_stall(id_stall), .rf_rr(rf_rr), .rf_q(rf_q), .ex_data(ex_data),
        .ex_data_ok(ex_data_ok), .exm_reg_write(exm_reg_write), .exm_dst(exm_dst),
        .exm_data(exm_data), .exm_data_ok(exm_data_ok), .wb_wr(wb_wr), .wb_rw(wb_rw),
        .wb_d(wb_d), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_dst(ex_dst),
        .ex_reg_write(ex_reg_write), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
    );

    int passed = 0;
    int total  = 0;

    // Reference model state (contents of ID/EX and the counter)
    logic          m_valid, m_rw;
    logic [AW-1:0] m_dst;
    logic [DW-1:0] m_a, m_b, m_imm;
    logic [CW-1:0] m_ctrl;
    logic [NW-1:0] m_cnt;
    // Model next state and expected combinational stall
    logic          n_valid, n_rw;
    logic [AW-1:0] n_dst;
    logic [DW-1:0] n_a, n_b, n_imm;
    logic [CW-1:0] n_ctrl;
    logic [NW-1:0] n_cnt;
    logic          e_stall;

    // Value of a source register as seen by ID, youngest writer first.
    task automatic resolve(input logic [AW-1:0] s, input logic use_s,
                           output logic [DW-1:0] v, output logic h);
        h = 1'b0;
        if (s == 0) v = '0;
        else if (m_valid && m_rw && m_dst == s) begin v = ex_data; h = !ex_data_ok; end
        else if (exm_reg_write && exm_dst == s) begin v = exm_data; h = !exm_data_ok; end
        else if (wb_wr && wb_rw == s) v = wb_d;
        else v = rf[s];
        h = h & use_s;
    endtask

    task automatic predict();
        logic [DW-1:0] va, vb;
        logic ha, hb, hz, hd;
        resolve(id_rs, id_use_rs, va, ha);
        resolve(id_rt, id_use_rt, vb, hb);
        hz = id_valid & (ha | hb);
        hd = m_valid & ~ex_ready;
        e_stall = id_valid & ~flush & (hz | hd);
        n_valid = m_valid; n_rw = m_rw; n_dst = m_dst; n_a = m_a; n_b = m_b;
        n_imm = m_imm; n_ctrl = m_ctrl; n_cnt = m_cnt;
        if (rst) begin
            n_valid = 0; n_rw = 0; n_dst = '0; n_a = '0; n_b = '0;
            n_imm = '0; n_ctrl = '0; n_cnt = '0;
        end else begin
            if (hz && !hd && !flush && m_cnt != '1) n_cnt = m_cnt + 1'b1;
            if (flush) begin
                n_valid = 0; n_rw = 0;
            end else if (!hd) begin
                if (id_valid && !hz) begin
                    n_valid = 1; n_rw = id_reg_write; n_dst = id_dst; n_a = va;
                    n_b = vb; n_imm = id_imm; n_ctrl = id_ctrl;
                end else begin
                    n_valid = 0; n_rw = 0;
                end
            end
        end
    endtask

    task automatic tick();
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        predict();
        w = wb_wr; a = wb_rw; d = wb_d;
        @(posedge clk);
        #1;
        if (w) rf[a] = d;
        m_valid = n_valid; m_rw = n_rw; m_dst = n_dst; m_a = n_a; m_b = n_b;
        m_imm = n_imm; m_ctrl = n_ctrl; m_cnt = n_cnt;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        id_dst = '0; id_reg_write = 0; id_ctrl = '0; id_imm = '0;
        ex_data = '0; ex_data_ok = 1; exm_reg_write = 0; exm_dst = '0;
        exm_data = '0; exm_data_ok = 1; wb_wr = 0; wb_rw = '0; wb_d = '0;
        flush = 0; ex_ready = 1;
    endtask

    // Issue a producer-only instruction (reads nothing) into ID/EX.
    task automatic issue(input logic [AW-1:0] dst, input logic [DW-1:0] imm);
        id_valid = 1; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        id_dst = dst; id_reg_write = 1; id_imm = imm; id_ctrl = 12'h5A5;
        tick();
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1; id_valid = 1; id_rs = 5'd3; id_rt = 5'd4; id_use_rs = 1;
        id_dst = 5'd2; id_reg_write = 1; id_imm = 32'hFFFF_0000; id_ctrl = 12'hFFF;
        tick(); tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ex_valid); else passed++;
        total++; if (stall_cnt !== '0) $display("FAIL reset_cnt: got %0d want 0", stall_cnt); else passed++;
        total++; if ({ex_a, ex_b, ex_imm, ex_dst, ex_reg_write, ex_ctrl} !== '0)
            $display("FAIL reset_regs: got a=%h b=%h imm=%h dst=%0d rw=%b ctrl=%h want all 0",
                     ex_a, ex_b, ex_imm, ex_dst, ex_reg_write, ex_ctrl);
        else passed++;
        rst = 0;
        set_idle();
    endtask

    task automatic test_basic();
        id_valid = 1; id_rs = 5'd3; id_rt = 5'd4; id_use_rs = 1; id_use_rt = 1;
        id_dst = 5'd10; id_reg_write = 1; id_imm = 32'h1234; id_ctrl = 12'hABC;
        #1;
        total++; if (rf_rr !== {5'd4, 5'd3}) $display("FAIL basic_rr: got %h want %h", rf_rr, {5'd4, 5'd3}); else passed++;
        total++; if (id_stall !== 1'b0) $display("FAIL basic_stall: got %b want 0", id_stall); else passed++;
        tick();
        total++; if (ex_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", ex_valid); else passed++;
        total++; if (ex_a !== 32'h11) $display("FAIL basic_a: got %h want 00000011", ex_a); else passed++;
        total++; if (ex_b !== rf[4]) $display("FAIL basic_b: got %h want %h", ex_b, rf[4]); else passed++;
        total++; if ({ex_imm, ex_ctrl, ex_dst, ex_reg_write} !== {32'h1234, 12'hABC, 5'd10, 1'b1})
            $display("FAIL basic_ctrl: got imm=%h ctrl=%h dst=%0d rw=%b want 1234/abc/10/1",
                     ex_imm, ex_ctrl, ex_dst, ex_reg_write);
        else passed++;
        set_idle();
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL basic_bubble: got %b want 0", ex_valid); else passed++;
    endtask

    task automatic test_ex_forward();
        set_idle();
        issue(5'd5, 32'h0);
        id_dst = 5'd6; id_reg_write = 0; id_rs = 5'd5; id_use_rs = 1;
        ex_data = 32'hAA; ex_data_ok = 1;
        #1;
        total++; if (id_stall !== 1'b0) $display("FAIL exfwd_stall: got %b want 0", id_stall); else passed++;
        tick();
        total++; if (ex_a !== 32'hAA) $display("FAIL exfwd_a: got %h want 000000aa", ex_a); else passed++;
        issue(5'd5, 32'h0);
        id_dst = 5'd6; id_reg_write = 0; id_rs = 5'd5; id_use_rs = 1;
        ex_data_ok = 0;
        #1;
        total++; if (id_stall !== 1'b1) $display("FAIL exload_stall: got %b want 1", id_stall); else passed++;
        tick();
        total++; if (ex_valid !== 1'b0) $display("FAIL exload_bubble: got %b want 0", ex_valid); else passed++;
        total++; if (stall_cnt !== 4'd1) $display("FAIL exload_cnt: got %0d want 1", stall_cnt); else passed++;
        #1;
        total++; if (id_stall !== 1'b0) $display("FAIL exload_release: got %b want 0", id_stall); else passed++;
        tick();
        total++; if (ex_a !== rf[5] || ex_valid !== 1'b1)
            $display("FAIL exload_rf: got a=%h v=%b want a=%h v=1", ex_a, ex_valid, rf[5]);
        else passed++;
        set_idle();
    endtask

    task automatic test_priority();
        set_idle();
        issue(5'd7, 32'h0);
        id_rs = 5'd7; id_use_rs = 1; id_dst = 5'd8; id_reg_write = 1;
        ex_data = 32'h1; ex_data_ok = 1;
        exm_reg_write = 1; exm_dst = 5'd7; exm_data = 32'h2; exm_data_ok = 1;
        wb_wr = 1; wb_rw = 5'd7; wb_d = 32'h3;
        tick();
        total++; if (ex_a !== 32'h1) $display("FAIL prio_idex: got %h want 00000001", ex_a); else passed++;
        tick();
        total++; if (ex_a !== 32'h2) $display("FAIL prio_exm: got %h want 00000002", ex_a); else passed++;
        exm_reg_write = 0;
        rf[7] = 32'hDEAD;
        tick();
        total++; if (ex_a !== 32'h3) $display("FAIL prio_wb: got %h want 00000003", ex_a); else passed++;
        set_idle();
    endtask

    task automatic test_zero();
        set_idle();
        issue(5'd0, 32'h0);
        ex_data = 32'h99; ex_data_ok = 0;
        exm_reg_write = 1; exm_dst = 5'd0; exm_data = 32'h77; exm_data_ok = 0;
        wb_wr = 1; wb_rw = 5'd0; wb_d = 32'h55;
        id_valid = 1; id_rs = 5'd0; id_use_rs = 1; id_rt = 5'd0; id_use_rt = 1;
        id_dst = 5'd1; id_reg_write = 0;
        #1;
        total++; if (id_stall !== 1'b0) $display("FAIL zero_stall: got %b want 0", id_stall); else passed++;
        tick();
        total++; if (ex_a !== '0 || ex_valid !== 1'b1)
            $display("FAIL zero_a: got a=%h v=%b want a=0 v=1", ex_a, ex_valid);
        else passed++;
        wb_wr = 0; exm_dst = 5'd9; id_rt = 5'd9; id_use_rt = 0;
        #1;
        total++; if (id_stall !== 1'b0) $display("FAIL unused_rt_stall: got %b want 0", id_stall); else passed++;
        id_use_rt = 1;
        #1;
        total++; if (id_stall !== 1'b1) $display("FAIL used_rt_stall: got %b want 1", id_stall); else passed++;
        set_idle();
        rf[0] = '0;
    endtask

    task automatic test_hold();
        logic [NW-1:0] cnt0;
        set_idle();
        issue(5'd12, 32'h77);
        total++; if (ex_valid !== 1'b1) $display("FAIL hold_issue: got %b want 1", ex_valid); else passed++;
        ex_ready = 0; ex_data_ok = 0;
        id_valid = 1; id_rs = 5'd12; id_use_rs = 1; id_dst = 5'd13; id_imm = 32'h88;
        cnt0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (id_stall !== 1'b1) $display("FAIL hold_stall%0d: got %b want 1", i, id_stall); else passed++;
            tick();
            total++; if (ex_valid !== 1'b1 || ex_imm !== 32'h77 || ex_dst !== 5'd12)
                $display("FAIL hold_keep%0d: got v=%b imm=%h dst=%0d want 1/77/12", i, ex_valid, ex_imm, ex_dst);
            else passed++;
            total++; if (stall_cnt !== cnt0) $display("FAIL hold_cnt%0d: got %0d want %0d", i, stall_cnt, cnt0); else passed++;
        end
        flush = 1;
        #1;
        total++; if (id_stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", id_stall); else passed++;
        tick();
        total++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0)
            $display("FAIL flush_drop: got v=%b rw=%b want 0/0", ex_valid, ex_reg_write);
        else passed++;
        set_idle();
    endtask

    task automatic test_random();
        set_idle();
        for (int c = 0; c < 300; c++) begin
            id_valid      = ($urandom_range(0, 9) < 8);
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_use_rs     = 1'($urandom);
            id_use_rt     = 1'($urandom);
            id_dst        = 5'($urandom_range(0, 7));
            id_reg_write  = 1'($urandom);
            id_ctrl       = 12'($urandom);
            id_imm        = $urandom;
            ex_data       = $urandom;
            ex_data_ok    = ($urandom_range(0, 9) < 7);
            exm_reg_write = 1'($urandom);
            exm_dst       = 5'($urandom_range(0, 7));
            exm_data      = $urandom;
            exm_data_ok   = ($urandom_range(0, 9) < 7);
            wb_wr         = 1'($urandom);
            wb_rw         = 5'($urandom_range(0, 7));
            wb_d          = $urandom;
            flush         = ($urandom_range(0, 9) == 0);
            ex_ready      = ($urandom_range(0, 3) != 0);
            #1;
            predict();
            total++; if (id_stall !== e_stall) $display("FAIL rnd_stall c%0d: got %b want %b", c, id_stall, e_stall); else passed++;
            tick();
            total++; if (ex_valid !== m_valid || ex_reg_write !== m_rw)
                $display("FAIL rnd_valid c%0d: got v=%b rw=%b want v=%b rw=%b", c, ex_valid, ex_reg_write, m_valid, m_rw);
            else passed++;
            total++; if (ex_a !== m_a || ex_b !== m_b)
                $display("FAIL rnd_ops c%0d: got a=%h b=%h want a=%h b=%h", c, ex_a, ex_b, m_a, m_b);
            else passed++;
            total++; if (ex_imm !== m_imm || ex_ctrl !== m_ctrl || ex_dst !== m_dst)
                $display("FAIL rnd_ctrl c%0d: got imm=%h ctrl=%h dst=%0d want imm=%h ctrl=%h dst=%0d",
                         c, ex_imm, ex_ctrl, ex_dst, m_imm, m_ctrl, m_dst);
            else passed++;
            total++; if (stall_cnt !== m_cnt) $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, stall_cnt, m_cnt); else passed++;
        end
        set_idle();
    endtask

    task automatic test_saturate();
        logic [NW-1:0] cnt0;
        set_idle();
        // Reset clears the counter so the run starts from a known value.
        rst = 1; tick(); rst = 0;
        exm_reg_write = 1; exm_dst = 5'd5; exm_data_ok = 0;
        id_valid = 1; id_rs = 5'd5; id_use_rs = 1;
        cnt0 = stall_cnt;
        for (int i = 0; i < 5; i++) tick();
        total++; if (stall_cnt !== 4'd5) $display("FAIL sat_count: got %0d want 5 (start %0d)", stall_cnt, cnt0); else passed++;
        for (int i = 0; i < 20; i++) tick();
        total++; if (stall_cnt !== 4'hF) $display("FAIL sat_max: got %0d want 15", stall_cnt); else passed++;
        total++; if (ex_valid !== 1'b0) $display("FAIL sat_bubble: got %b want 0", ex_valid); else passed++;
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = '0;
        rf[3] = 32'h11;
        m_valid = 0; m_rw = 0; m_dst = '0; m_a = '0; m_b = '0;
        m_imm = '0; m_ctrl = '0; m_cnt = '0;
        rst = 1;
        set_idle();
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_ex_forward();
        test_priority();
        test_zero();
        test_hold();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_id_ex_operand_stage
`default_nettype wire
